// File: rtl/serial_add_sequencer_pkg.sv
// serial_add_pkg: shared state encoding and default width for the bit-serial adder.
package serial_add_pkg;
   localparam int SA_WIDTH = 32;
   typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;
endpackage

// File: rtl/serial_add_sequencer_if.sv
// serial_add_sequencer_if: start/busy/done request bus between issuing control and the serial adder.
interface serial_add_sequencer_if
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SA_WIDTH
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             zero;
   modport master (
      output start, sub, a, b,
      input  busy, done, result, carry_out, overflow, zero
   );
   modport slave (
      input  start, sub, a, b,
      output busy, done, result, carry_out, overflow, zero
   );
endinterface

// File: rtl/serial_add_sequencer_full_adder.sv
// full_adder: 1-bit full adder from two half-adder cells; the only arithmetic in the serial adder.
module half_adder (
   input  logic i_a,
   input  logic i_b,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b;
   assign o_c = i_a & i_b;
endmodule

module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   logic w_s0, w_c0, w_c1;
   half_adder u_ha0 (.i_a(i_a),  .i_b(i_b), .o_s(w_s0), .o_c(w_c0));
   half_adder u_ha1 (.i_a(w_s0), .i_b(i_c), .o_s(o_s),  .o_c(w_c1));
   assign o_c = w_c0 | w_c1;
endmodule

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: WIDTH-cycle LSB-first add/subtract sequencing one shared full adder.
module serial_add_sequencer
   import serial_add_pkg::*;
#(
   parameter  int WIDTH = SA_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   serial_add_sequencer_if.slave bus
);
   sa_state_t        r_state;
   logic [WIDTH-1:0] r_a, r_b, r_sh, r_result;
   logic [CNT_W-1:0] r_cnt;
   logic             r_c, r_busy, r_done, r_cout, r_ovf, r_zero;
   logic             w_s, w_co, w_last;
   logic [WIDTH-1:0] w_sum;

   full_adder u_fa (.i_a(r_a[0]), .i_b(r_b[0]), .i_c(r_c), .o_s(w_s), .o_c(w_co));

   assign w_sum  = {w_s, r_sh[WIDTH-1:1]};
   assign w_last = r_cnt == CNT_W'(WIDTH - 1);

   // on the last bit r_c is the carry into the MSB, so overflow is r_c ^ w_co
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_sh     <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_c      <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.sub ? ~bus.b : bus.b;
                  r_c     <= bus.sub;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_sh  <= w_sum;
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_c   <= w_co;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_result <= w_sum;
                  r_cout   <= w_co;
                  r_ovf    <= r_c ^ w_co;
                  r_zero   <= ~|w_sum;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.result    = r_result;
   assign bus.carry_out = r_cout;
   assign bus.overflow  = r_ovf;
   assign bus.zero      = r_zero;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: directed and random checks of the serial adder against an arithmetic model.
module tb_serial_add_sequencer;
   localparam int W = 32;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_cmp = 0;
   int n_fail = 0;
   logic [W-1:0] prev_res = '0;
   logic [34:0] ops [0:101];

   serial_add_sequencer_if #(.WIDTH(W)) bus ();
   serial_add_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // returns {overflow, zero, carry_out, result}
   function automatic logic [34:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      logic [W:0] t;
      logic [W-1:0] r;
      logic ov;
      t  = s ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
      r  = t[W-1:0];
      ov = s ? ((a[W-1] != b[W-1]) && (r[W-1] != a[W-1])) : ((a[W-1] == b[W-1]) && (r[W-1] != a[W-1]));
      return {ov, r == '0, t[W], r};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic [34:0] m);
      chk({tag, ".result"}, 64'(bus.result), 64'(m[W-1:0]));
      chk({tag, ".carry"}, 64'(bus.carry_out), 64'(m[W]));
      chk({tag, ".zero"}, 64'(bus.zero), 64'(m[W+1]));
      chk({tag, ".ovf"}, 64'(bus.overflow), 64'(m[W+2]));
   endtask

   task automatic wait_done(input string tag, input logic [34:0] m, input int start_k);
      int k = start_k;
      while (!bus.done && k < 40) begin
         if (k == 16) chk({tag, ".hold"}, 64'(bus.result), 64'(prev_res));
         @(negedge clk);
         k++;
      end
      chk({tag, ".latency"}, 64'(k), 64'd33);
      chk_res(tag, m);
      prev_res = m[W-1:0];
      @(negedge clk);
      chk({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
      chk({tag, ".busy_end"}, 64'(bus.busy), 64'd0);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input string tag);
      @(negedge clk);
      bus.start = 1'b1; bus.a = a; bus.b = b; bus.sub = s;
      @(negedge clk);
      bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.sub = 1'($urandom);
      chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
      wait_done(tag, model(a, b, s), 1);
   endtask

   task automatic no_done(input string tag);
      int cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) cnt++;
      end
      chk(tag, 64'(cnt), 64'd0);
   endtask

   initial begin
      bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
      repeat (2) @(negedge clk);
      chk("rst.busy", 64'(bus.busy), 64'd0);
      chk("rst.done", 64'(bus.done), 64'd0);
      chk_res("rst", 35'd0);
      reset = 1'b0;
      run_op(32'd5, 32'd3, 1'b0, "add");
      run_op(32'd3, 32'd5, 1'b1, "sub_borrow");
      run_op(32'd7, 32'd7, 1'b1, "sub_zero");
      run_op(32'h7FFF_FFFF, 32'd1, 1'b0, "ovf");
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "wrap");
      // second start mid-run must be ignored
      @(negedge clk);
      bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1; bus.sub = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd100; bus.sub = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("ignore", model(32'd1, 32'd1, 1'b0), 11);
      no_done("ignore.extra");
      // asynchronous reset mid-operation
      @(negedge clk);
      bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd9; bus.sub = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (14) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mrst.busy", 64'(bus.busy), 64'd0);
      chk("mrst.done", 64'(bus.done), 64'd0);
      chk_res("mrst", 35'd0);
      @(negedge clk);
      reset = 1'b0;
      prev_res = '0;
      no_done("mrst.nodone");
      run_op(32'd2, 32'd2, 1'b0, "after_rst");
      // back-to-back with start held high and operands changing every cycle
      @(negedge clk);
      bus.start = 1'b1;
      for (int e = 0; e < 102; e++) begin
         bus.a = $urandom; bus.b = $urandom; bus.sub = 1'($urandom);
         ops[e] = {bus.sub, bus.b, 2'b00, bus.a[0]};
         ops[e] = model(bus.a, bus.b, bus.sub);
         @(negedge clk);
         chk("b2b.done", 64'(bus.done), 64'(e % 34 == 32));
         if (e % 34 == 32) chk_res("b2b", ops[e - 32]);
      end
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      prev_res = bus.result;
      chk("b2b.final", 64'(prev_res), 64'(ops[68][W-1:0]));
      for (int i = 0; i < 12; i++) begin
         logic [W-1:0] ra, rb;
         ra = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
         rb = (i % 4 == 1) ? ra : $urandom;
         run_op(ra, rb, 1'($urandom), "rand");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Multi-cycle, bit-serial add/subtract unit for the MIPS datapath. Area-reduced alternative to the 32-bit ripple adder in low-area configurations.
- Sequences one shared 1-bit full adder, built from two half-adder cells, across WIDTH cycles. Operand bits are fed LSB-first from shift registers; the carry is held in a flip-flop between bits.
- Uses a start/busy/done handshake toward the issuing control logic.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  single-cycle pulse; result and flags are valid.
- result  output  WIDTH  sum/difference; held until the next completion.
- carry_out  output  1  carry out of MSB (for sub: 1 = no borrow).
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  result == 0.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0.
  - Shift registers, counter and carry FF cleared.
  - An in-flight operation is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge loads a into the A shift register.
  - Loads b into the B shift register, or ~b if sub=1.
  - carry FF = sub; counter = 0; state -> RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Full adder computes s = A[0]^B[0]^c and c' = majority.
  - s is shifted into the MSB of the result shift register; A and B shift right; carry FF = c'.
  - The carry into the current bit is captured when counter == WIDTH-1; this is the MSB carry-in.
  - Counter increments. When counter == WIDTH-1 at the edge, state -> DONE.
- Entering DONE:
  - result, carry_out (= final c'), overflow and zero are registered from the completed shift register.
  - done=1 for exactly one cycle; state -> IDLE at the next edge.
- Latency: if start is sampled at edge E0, done is high between edges E0+WIDTH and E0+WIDTH+1. The earliest next accepted start is at edge E0+WIDTH+2.
- start during RUN or DONE is ignored: no queueing, no restart, no error.
- Changes to a, b or sub after the start edge have no effect.
- Arithmetic is modulo 2^WIDTH. Subtraction is two's complement (~b + 1 via carry-in).
- result and flags are not modified during RUN; they always show the last completed operation.

Decomposition:
- Package serial_add_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t; localparam for the default WIDTH.
- One sub-module, full_adder: 1-bit, two half_adder instances plus an OR for carry. It is the only arithmetic in the block.
- Sequencing, shift registers and flag logic stay in serial_add_sequencer.

Test Plan:
- Add, WIDTH=32: a=5, b=3, sub=0, start pulsed → busy=1 next cycle; done exactly 32 edges after start edge; result=8, carry_out=0, overflow=0, zero=0.
- Sub with borrow: a=3, b=5, sub=1 → result=0xFFFFFFFE, carry_out=0, overflow=0, zero=0.
- Zero/overflow:
  - a=7, b=7, sub=1 → result=0, zero=1, carry_out=1.
  - a=0x7FFFFFFF, b=1, sub=0 → result=0x80000000, overflow=1, carry_out=0.
  - a=0xFFFFFFFF, b=1 → result=0, carry_out=1, zero=1, overflow=0.
- Ignored start: a=1, b=1, start; at cycle 10 assert start with a=100, b=100 and change inputs → single done pulse at cycle 32, result=2; no second done.
- Reset mid-op: start a=9, b=9; assert reset at cycle 15 → busy, done and outputs 0 immediately (asynchronous); after release, no done; a new start (a=2, b=2) completes normally with result=4.
- Back-to-back: hold start=1 continuously → done pulses every WIDTH+2 cycles; each result matches its operands captured at the accepting edge.
